// File: rtl/lcd_pio_seq_pkg.sv
// Shared constants for the LCD control PIO: register map, bit positions and sequencer states.
// The optional interrupt feature is selected with LCD_PIO_IRQ_EN.
package lcd_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_SET      = 3'd1;
   localparam logic [2:0] ADDR_CLR      = 3'd2;
   localparam logic [2:0] ADDR_PULSE    = 3'd3;
   localparam logic [2:0] ADDR_STATUS   = 3'd4;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;

   localparam int START_BIT = 31;
   localparam int DONE_BIT  = 1;
   localparam int BUSY_BIT  = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RECOVER = 2'd2
   } seq_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_pio_seq_if.sv
// Avalon-MM slave bus bundle for the LCD control PIO (zero wait states, combinational readdata).
interface lcd_pio_seq_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, output chipselect, output write_n, output writedata,
                   input readdata);
   modport slave  (input address, input chipselect, input write_n, input writedata,
                   output readdata);
endinterface

// File: rtl/lcd_pio_seq_pulse_timer.sv
// Pulse sequencer FSM: holds ASSERT for PULSE_CYCLES cycles, then RECOVER for RECOVER_CYCLES,
// then returns to IDLE with a one-cycle done_pulse.
module lcd_pio_pulse_timer
   import lcd_pio_pkg::*;
#(
   parameter int PULSE_CYCLES   = 50000,
   parameter int RECOVER_CYCLES = 6000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic busy,
   output logic assert_active,
   output logic done_pulse
);

   localparam int CW = $clog2(max3(PULSE_CYCLES, RECOVER_CYCLES, 2));
   localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LOAD = CW'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);
   localparam logic [CW-1:0] ONE          = CW'(1);
   localparam logic [CW-1:0] ZERO         = CW'(0);

   seq_state_e    state_r, state_s;
   logic [CW-1:0] count_r, count_s;

   // State and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         count_r <= ZERO;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
      end
   end

   // Next-state and counter logic; the counter only ever counts down from a load to zero.
   always_comb begin
      state_s    = state_r;
      count_s    = count_r;
      done_pulse = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = ASSERT;
               count_s = PULSE_LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         ASSERT: begin
            if (count_r != ZERO) begin
               count_s = count_r - ONE;
            end else if (RECOVER_CYCLES == 0) begin
               state_s    = IDLE;
               done_pulse = 1'b1;
            end else begin
               state_s = RECOVER;
               count_s = RECOVER_LOAD;
            end
         end
         RECOVER: begin
            if (count_r != ZERO) begin
               count_s = count_r - ONE;
            end else begin
               state_s    = IDLE;
               done_pulse = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
            count_s = ZERO;
         end
      endcase
   end

   assign busy          = (state_r != IDLE);
   assign assert_active = (state_r == ASSERT);

endmodule

// File: rtl/lcd_pio_seq.sv
// Avalon-MM output PIO for TFT LCD control pins with set/clear, readback and a timed pulse on
// one bit. Define LCD_PIO_IRQ_EN to add the IRQ_MASK register and the irq output.
module lcd_pio_seq
   import lcd_pio_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter int               PULSE_CYCLES   = 50000,
   parameter int               RECOVER_CYCLES = 6000000,
   parameter logic             PULSE_LEVEL    = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   lcd_pio_seq_if.slave     bus,
`ifdef LCD_PIO_IRQ_EN
   output logic             irq,
`endif
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_r, data_s, out_s;
   logic [4:0]       sel_r;
   logic             done_r, done_s, clr_done_s;
   logic             wr_s, start_s, busy_s, assert_s, done_pulse_s;
   logic [31:0]      rd_s;
`ifdef LCD_PIO_IRQ_EN
   logic             mask_r, mask_s, irq_r;
`endif

   lcd_pio_pulse_timer #(
      .PULSE_CYCLES   (PULSE_CYCLES),
      .RECOVER_CYCLES (RECOVER_CYCLES)
   ) u_timer (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start_s),
      .busy          (busy_s),
      .assert_active (assert_s),
      .done_pulse    (done_pulse_s)
   );

   // Write decode; a start is only accepted from IDLE with an in-range bit select.
   always_comb begin
      wr_s       = bus.chipselect & ~bus.write_n;
      data_s     = data_r;
      start_s    = 1'b0;
      clr_done_s = 1'b0;
`ifdef LCD_PIO_IRQ_EN
      mask_s     = mask_r;
`endif
      if (wr_s) begin
         case (bus.address)
            ADDR_DATA:   data_s = bus.writedata[WIDTH-1:0];
            ADDR_SET:    data_s = data_r | bus.writedata[WIDTH-1:0];
            ADDR_CLR:    data_s = data_r & ~bus.writedata[WIDTH-1:0];
            ADDR_PULSE:  start_s = bus.writedata[START_BIT] & ~busy_s &
                                   ({1'b0, bus.writedata[4:0]} < 6'(WIDTH));
            ADDR_STATUS: clr_done_s = bus.writedata[DONE_BIT];
`ifdef LCD_PIO_IRQ_EN
            ADDR_IRQ_MASK: mask_s = bus.writedata[0];
`endif
            default:     data_s = data_r;
         endcase
      end else begin
         data_s = data_r;
      end
      // Completion wins over a simultaneous clear.
      done_s = done_pulse_s ? 1'b1 : (clr_done_s ? 1'b0 : done_r);
   end

   // Programmer-visible registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= RESET_VALUE;
         sel_r  <= 5'd0;
         done_r <= 1'b0;
`ifdef LCD_PIO_IRQ_EN
         mask_r <= 1'b0;
         irq_r  <= 1'b0;
`endif
      end else begin
         data_r <= data_s;
         sel_r  <= start_s ? bus.writedata[4:0] : sel_r;
         done_r <= done_s;
`ifdef LCD_PIO_IRQ_EN
         mask_r <= mask_s;
         irq_r  <= done_s & mask_s;
`endif
      end
   end

   // Output mux: the selected bit is overridden only while the sequencer is in ASSERT.
   always_comb begin
      out_s = data_r;
      for (int i = 0; i < WIDTH; i++) begin
         if (assert_s && (sel_r == 5'(i))) out_s[i] = PULSE_LEVEL;
         else                             out_s[i] = data_r[i];
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      rd_s = 32'd0;
      case (bus.address)
         ADDR_DATA:     rd_s[WIDTH-1:0] = data_r;
         ADDR_PULSE:    rd_s = {busy_s, 26'd0, sel_r};
         ADDR_STATUS:   rd_s = {30'd0, done_r, busy_s};
`ifdef LCD_PIO_IRQ_EN
         ADDR_IRQ_MASK: rd_s = {31'd0, mask_r};
`endif
         default:       rd_s = 32'd0;
      endcase
   end

   assign bus.readdata = rd_s;
   assign out_port     = out_s;
`ifdef LCD_PIO_IRQ_EN
   assign irq          = irq_r;
`endif

endmodule

// File: tb/tb_lcd_pio_seq.sv
// Randomized self-checking bench for lcd_pio_seq against a cycle-window reference model.
// Covers the irq path when LCD_PIO_IRQ_EN is defined.
module tb_lcd_pio_seq;
   import lcd_pio_pkg::*;

   localparam int         W  = 8;
   localparam int         P  = 4;
   localparam int         R  = 3;
   localparam logic [7:0] RV = 8'h01;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] out_port;
`ifdef LCD_PIO_IRQ_EN
   logic       irq;
`endif

   always #10 clk = ~clk;

   lcd_pio_seq_if bus ();

   lcd_pio_seq #(
      .WIDTH          (W),
      .RESET_VALUE    (RV),
      .PULSE_CYCLES   (P),
      .RECOVER_CYCLES (R),
      .PULSE_LEVEL    (1'b0)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
`ifdef LCD_PIO_IRQ_EN
      .irq      (irq),
`endif
      .out_port (out_port)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a sequence started at edge t0 is asserting on cycles [t0, t0+P)
   // and busy on [t0, t0+P+R); done appears at cycle t0+P+R.
   int         cyc = 0;
   int         t0  = 0;
   bit         seq_on;
   logic [7:0] m_data;
   logic [4:0] m_sel;
   logic       m_done;
   logic       m_mask;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit m_busy(input int c);
      return seq_on && (c >= t0) && (c < t0 + P + R);
   endfunction

   function automatic bit m_assert(input int c);
      return seq_on && (c >= t0) && (c < t0 + P);
   endfunction

   function automatic logic [7:0] m_out();
      logic [7:0] o;
      o = m_data;
      if (m_assert(cyc)) o[m_sel[2:0]] = 1'b0;
      return o;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {24'd0, m_data};
         3'd3:    return {m_busy(cyc), 26'd0, m_sel};
         3'd4:    return {30'd0, m_done, m_busy(cyc)};
`ifdef LCD_PIO_IRQ_EN
         3'd5:    return {31'd0, m_mask};
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      seq_on = 1'b0;
      m_data = RV;
      m_sel  = 5'd0;
      m_done = 1'b0;
      m_mask = 1'b0;
   endtask

   task automatic model_write(input logic [2:0] a, input logic [31:0] d);
      case (a)
         3'd0: m_data = d[7:0];
         3'd1: m_data = m_data | d[7:0];
         3'd2: m_data = m_data & ~d[7:0];
         3'd3: if (d[31] && !m_busy(cyc) && d[4:0] < 5'd8) begin
                  m_sel  = d[4:0];
                  seq_on = 1'b1;
                  t0     = cyc + 1;
               end
         3'd4: if (d[1]) m_done = 1'b0;
`ifdef LCD_PIO_IRQ_EN
         3'd5: m_mask = d[0];
`endif
         default: ;
      endcase
   endtask

   task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
      bus.address = a;
      #1;
      check_eq(tag, bus.readdata, exp);
   endtask

   task automatic check_all();
      logic [2:0] ra;
      check_eq("out_port", {24'd0, out_port}, {24'd0, m_out()});
`ifdef LCD_PIO_IRQ_EN
      check_eq("irq", {31'd0, irq}, {31'd0, m_done & m_mask});
`endif
      read_check("rd_status", 3'd4, m_read(3'd4));
      read_check("rd_pulse", 3'd3, m_read(3'd3));
      ra = 3'($urandom_range(0, 7));
      read_check("rd_any", ra, m_read(ra));
   endtask

   // One clock: present a bus cycle, advance the model across the edge, then check.
   task automatic bus_cycle(input logic wr, input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = wr ? 1'b1 : 1'($urandom_range(0, 1));
      bus.write_n    = ~wr;
      if (wr) model_write(a, d);
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      cyc++;
      if (seq_on && cyc == t0 + P + R) begin
         m_done = 1'b1;
         seq_on = 1'b0;
      end
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(1'b0, 3'd0, 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_out", {24'd0, out_port}, {24'd0, RV});
      read_check("rst_status", 3'd4, 32'd0);
      read_check("rst_data", 3'd0, {24'd0, RV});
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      logic [2:0]  a;
      logic [31:0] d;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'd0;
      reset_n        = 1'b0;
      model_reset();
      #25;
      check_eq("rst_out", {24'd0, out_port}, 32'h01);
      for (int i = 0; i < 8; i++) read_check("rst_reg", 3'(i), (i == 0) ? 32'h1 : 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // Plain data, set and clear.
      bus_cycle(1'b1, 3'd0, 32'h0000_00A5);
      check_eq("data_a5", {24'd0, out_port}, 32'hA5);
      bus_cycle(1'b1, 3'd1, 32'hFFFF_FF0A);
      check_eq("set_af", {24'd0, out_port}, 32'hAF);
      bus_cycle(1'b1, 3'd2, 32'h0000_0081);
      check_eq("clr_2e", {24'd0, out_port}, 32'h2E);
      read_check("rd_set", 3'd1, 32'd0);
      read_check("rd_clr", 3'd2, 32'd0);

      // Full pulse on bit 0, with an ignored start while busy.
      bus_cycle(1'b1, 3'd0, 32'h0000_00FF);
      bus_cycle(1'b1, 3'd3, 32'h8000_0000);
      check_eq("pulse_c1", {24'd0, out_port}, 32'hFE);
      bus_cycle(1'b1, 3'd3, 32'h8000_0001);
      check_eq("pulse_c2", {24'd0, out_port}, 32'hFE);
      idle(2);
      check_eq("pulse_c4", {24'd0, out_port}, 32'hFE);
      idle(1);
      check_eq("after_pulse", {24'd0, out_port}, 32'hFF);
      idle(2);
      read_check("busy_c7", 3'd4, 32'h1);
      idle(1);
      read_check("done_set", 3'd4, 32'h2);

      // Out-of-range select is ignored; W1C clears done.
      bus_cycle(1'b1, 3'd3, 32'h8000_0009);
      read_check("sel9_ign", 3'd3, 32'h0);
      bus_cycle(1'b1, 3'd4, 32'h0000_0002);
      read_check("done_w1c", 3'd4, 32'h0);

      // DATA write mid-ASSERT, then reset mid-RECOVER.
      bus_cycle(1'b1, 3'd3, 32'h8000_0002);
      bus_cycle(1'b1, 3'd0, 32'h0000_00F0);
      check_eq("mid_assert", {24'd0, out_port}, 32'hF0);
      idle(3);
      check_eq("in_recover", {24'd0, out_port}, 32'hF0);
      do_reset();

`ifdef LCD_PIO_IRQ_EN
      bus_cycle(1'b1, 3'd5, 32'h1);
      bus_cycle(1'b1, 3'd3, 32'h8000_0003);
      idle(P + R);
      check_eq("irq_rise", {31'd0, irq}, 32'h1);
      bus_cycle(1'b1, 3'd4, 32'h2);
      check_eq("irq_fall", {31'd0, irq}, 32'h0);
      bus_cycle(1'b1, 3'd5, 32'h0);
      bus_cycle(1'b1, 3'd3, 32'h8000_0004);
      idle(P + R + 1);
      check_eq("irq_masked", {31'd0, irq}, 32'h0);
`endif

      // Random traffic, biased toward PULSE and STATUS, with occasional resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 1) == 0) begin
            bus_cycle(1'b0, 3'($urandom_range(0, 7)), $urandom);
         end else begin
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) a = 3'd3;
            d = $urandom;
            if (a == 3'd3) d = {($urandom_range(0, 3) != 0), d[30:5], 5'($urandom_range(0, 9))};
            bus_cycle(1'b1, a, d);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_pio_seq.md
Name: lcd_pio_seq

Overview:
- Parametrised Avalon-MM output PIO; successor to the single-bit LCD control ports (nRST, CS, backlight).
- Adds atomic bit set/clear, readback and a hardware-timed pulse sequencer on one selectable bit.
- The sequencer drives a bit to PULSE_LEVEL for a fixed time, then waits a recovery time, so LCD reset timing no longer depends on software delay loops.
- Sits on the Nios II system interconnect; out_port goes to the TFT LCD control pins.

Parameters:
- WIDTH, 8: output port width, 1..32.
- RESET_VALUE, 0: out_port and DATA value after reset, WIDTH bits.
- PULSE_CYCLES, 50000: cycles in ASSERT; minimum 1.
- RECOVER_CYCLES, 6000000: cycles in RECOVER; minimum 0; 0 means no recover time.
- PULSE_LEVEL, 0: level forced on the selected bit during ASSERT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero wait states, combinational
- out_port  out  WIDTH  LCD control outputs
- irq  out  1  completion interrupt; present only with LCD_PIO_IRQ_EN

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: DATA=RESET_VALUE, state=IDLE, counter=0, sel=0, done=0, irq_mask=0, irq=0, out_port=RESET_VALUE.
- A write is chipselect & ~write_n; it takes effect at the next clk edge. Unused writedata bits are ignored.
- Register 0, DATA: RW. Read returns DATA zero-extended to 32 bits.
- Register 1, SET: W. DATA |= writedata[WIDTH-1:0]. Reads 0.
- Register 2, CLR: W. DATA &= ~writedata[WIDTH-1:0]. Reads 0.
- Register 3, PULSE: W. writedata[4:0]=sel, writedata[31]=start. Read returns {busy, 26'b0, sel}.
  - Start is accepted only when state==IDLE and sel<WIDTH. Otherwise the whole write is ignored and sel is not updated.
- Register 4, STATUS: R returns {30'b0, done, busy}. Writing 1 to bit1 clears done.
- Register 5, IRQ_MASK: bit0. Exists only with the macro; otherwise reads 0 and writes are ignored.
- Registers 6 and 7: read 0, writes ignored.
- FSM states: IDLE, ASSERT, RECOVER.
  - IDLE -> ASSERT on accepted start. Counter loads PULSE_CYCLES-1.
  - ASSERT: decrement each cycle. At 0, go to RECOVER with counter loaded RECOVER_CYCLES-1; if RECOVER_CYCLES==0, go to IDLE directly.
  - RECOVER: decrement each cycle. At 0, go to IDLE and set done.
- busy = (state != IDLE).
- out_port = DATA, except bit sel, which is PULSE_LEVEL while state==ASSERT.
  - The override is registered: it starts on the edge that accepts start and lasts exactly PULSE_CYCLES cycles.
  - After ASSERT, the bit shows DATA[sel] again.
- Writes to DATA, SET or CLR during a sequence update DATA immediately. The selected bit stays overridden until ASSERT ends.
- The counter is sized $clog2(max(PULSE_CYCLES, RECOVER_CYCLES, 2)) bits. No wrap: it only decrements from a loaded value to 0.
- If done is set and cleared by W1C in the same cycle, set wins.
- A start written on the same edge the FSM returns to IDLE is ignored, because the FSM is not yet IDLE.
- reset_n asserted mid-sequence aborts immediately: all values return to reset, out_port=RESET_VALUE.

Optional Feature:
- Macro LCD_PIO_IRQ_EN.
- Defined: IRQ_MASK register and irq port exist. irq = done & irq_mask, registered, cleared with done.
- Undefined: no irq port; register 5 behaves as reserved; done is polled only.

Decomposition:
- Package lcd_pio_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_PULSE=3, ADDR_STATUS=4, ADDR_IRQ_MASK=5.
  - FSM state enum: IDLE, ASSERT, RECOVER.
  - bit positions: START_BIT=31, DONE_BIT=1, BUSY_BIT=0.
- One sub-module, lcd_pio_pulse_timer, contains the FSM and the down-counter. Its interface is start, busy, assert_active and done_pulse.

Test Plan (WIDTH=8, RESET_VALUE=8'h01, PULSE_CYCLES=4, RECOVER_CYCLES=3, PULSE_LEVEL=0):
- Reset -> out_port=8'h01, all reads 0 except DATA=1. Write DATA=8'hA5 -> out_port=8'hA5 on the next cycle and readback 8'hA5.
- From DATA=8'hA5: SET 8'h0A -> 8'hAF; then CLR 8'h81 -> 8'h2E. Reads of SET and CLR return 0.
- DATA=8'hFF, PULSE write 32'h8000_0000 (sel=0) -> out_port=8'hFE for exactly 4 cycles, then 8'hFF. busy stays 1 for 7 cycles. done=1 on the following read.
- Start while busy -> ignored, sequence length unchanged. Start with sel=9 -> ignored, busy stays 0. W1C STATUS bit1 -> done=0.
- DATA write 8'h00 mid-ASSERT -> bit0 stays 0, other bits follow 8'h00. reset_n low mid-RECOVER -> out_port=8'h01, busy=0, done=0.
- With LCD_PIO_IRQ_EN: IRQ_MASK=1 -> irq rises when the sequence completes and falls after the done W1C. IRQ_MASK=0 -> irq stays 0.
